// File: rtl/controle_cifra_if.sv
// rtl/controle_cifra_if.sv - handshake, result and round-datapath signal bundle for controle_cifra
interface controle_cifra_if;
  logic         ent_valido;
  logic         ent_pronto;
  logic [127:0] bloco;
  logic [127:0] chave;
  logic         saida_valida;
  logic         saida_pronta;
  logic [127:0] saida;
  logic         ocupado;
  logic [15:0]  blocos_cifrados;
  logic [127:0] dp_estado;
  logic [127:0] dp_chave;
  logic [7:0]   dp_rcon;
  logic         dp_ultima;
  logic [127:0] dp_estado_novo;
  logic [127:0] dp_chave_nova;

  modport slave (
    input  ent_valido, bloco, chave, saida_pronta, dp_estado_novo, dp_chave_nova,
    output ent_pronto, saida_valida, saida, ocupado, blocos_cifrados,
           dp_estado, dp_chave, dp_rcon, dp_ultima
  );

  modport master (
    output ent_valido, bloco, chave, saida_pronta, dp_estado_novo, dp_chave_nova,
    input  ent_pronto, saida_valida, saida, ocupado, blocos_cifrados,
           dp_estado, dp_chave, dp_rcon, dp_ultima
  );
endinterface

// File: rtl/controle_cifra.sv
// rtl/controle_cifra.sv - AES-128 round sequencer: loads block/key, steps 10 rounds through an
// external datapath and holds the ciphertext until the consumer takes it.
module controle_cifra #(
  parameter bit INVERTE = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  controle_cifra_if.slave bus
);
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    RODADA = 2'd1,
    FINAL  = 2'd2
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] estado_q, estado_d;
  logic [127:0] chave_q, chave_d;
  logic [3:0]   rodada_q, rodada_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [15:0]  blocos_q, blocos_d;
  logic [127:0] bloco_ord, chave_ord;

  // Byte i swaps with byte 15-i so the datapath sees AES byte 0 in the low byte.
  function automatic logic [127:0] ordena(input logic [127:0] v);
    logic [127:0] r;
    r = v;
    if (INVERTE) begin
      for (int i = 0; i < 16; i++) begin
        r[8*i +: 8] = v[8*(15-i) +: 8];
      end
    end
    return r;
  endfunction

  always_comb begin
    bloco_ord = ordena(bus.bloco);
    chave_ord = ordena(bus.chave);
  end

  always_comb begin
    fsm_d    = fsm_q;
    estado_d = estado_q;
    chave_d  = chave_q;
    rodada_d = rodada_q;
    rcon_d   = rcon_q;
    blocos_d = blocos_q;
    unique case (fsm_q)
      OCIOSO: begin
        if (bus.ent_valido) begin
          estado_d = bloco_ord ^ chave_ord;
          chave_d  = chave_ord;
          rodada_d = 4'd1;
          rcon_d   = 8'h01;
          fsm_d    = RODADA;
        end
      end
      RODADA: begin
        estado_d = bus.dp_estado_novo;
        chave_d  = bus.dp_chave_nova;
        rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
        if (rodada_q == 4'd10) begin
          rodada_d = 4'd0;
          fsm_d    = FINAL;
        end else begin
          rodada_d = rodada_q + 4'd1;
        end
      end
      FINAL: begin
        if (bus.saida_pronta) begin
          blocos_d = blocos_q + 16'd1;
          fsm_d    = OCIOSO;
        end
      end
      default: fsm_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q    <= OCIOSO;
      estado_q <= '0;
      chave_q  <= '0;
      rodada_q <= 4'd0;
      rcon_q   <= 8'h01;
      blocos_q <= 16'd0;
    end else begin
      fsm_q    <= fsm_d;
      estado_q <= estado_d;
      chave_q  <= chave_d;
      rodada_q <= rodada_d;
      rcon_q   <= rcon_d;
      blocos_q <= blocos_d;
    end
  end

  // Every output is a function of registered state only.
  assign bus.ent_pronto      = (fsm_q == OCIOSO);
  assign bus.ocupado         = (fsm_q != OCIOSO);
  assign bus.saida_valida    = (fsm_q == FINAL);
  assign bus.saida           = (fsm_q == FINAL) ? ordena(estado_q) : '0;
  assign bus.blocos_cifrados = blocos_q;
  assign bus.dp_estado       = estado_q;
  assign bus.dp_chave        = chave_q;
  assign bus.dp_rcon         = rcon_q;
  assign bus.dp_ultima       = (fsm_q == RODADA) && (rodada_q == 4'd10);
endmodule
